// File: rtl/spi_master_pkg.sv
// Shared types and constants for the single-byte SPI master.
// Optional busy output is enabled with SPI_MASTER_BUSY_EN (see spi_master.sv).
package spi_master_pkg;

  localparam int DW_DEF = 8;
  localparam int HCW    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Half-period minus one, in clk cycles, for each cdiv code
  localparam logic [HCW-1:0] HALF_M1_DIV4  = 4'd1;
  localparam logic [HCW-1:0] HALF_M1_DIV8  = 4'd3;
  localparam logic [HCW-1:0] HALF_M1_DIV16 = 4'd7;
  localparam logic [HCW-1:0] HALF_M1_DIV32 = 4'd15;

  function automatic logic [HCW-1:0] half_m1(input logic [1:0] cdiv);
    logic [HCW-1:0] h;
    case (cdiv)
      2'b00:   h = HALF_M1_DIV4;
      2'b01:   h = HALF_M1_DIV8;
      2'b10:   h = HALF_M1_DIV16;
      default: h = HALF_M1_DIV32;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCK generator: toggles sck every (half_m1+1) clks while enabled, flags the edges.
// Held in reset (sck low, counter zero) whenever en is low.
module spi_clk_div
  import spi_master_pkg::*;
(
  input  logic           clk,
  input  logic           rstb,
  input  logic           en,
  input  logic [HCW-1:0] half_m1,
  output logic           sck,
  output logic           sck_rise,
  output logic           sck_fall
);

  localparam logic [HCW-1:0] CNT_ONE = 4'd1;

  logic [HCW-1:0] cnt_r;
  logic           sck_r;
  logic           tick_s;

  // Half-period expiry strobe
  always_comb begin
    tick_s = en && (cnt_r == half_m1);
  end

  // Half-period counter and sck level
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_r <= '0;
      sck_r <= 1'b0;
    end else if (!en) begin
      cnt_r <= '0;
      sck_r <= 1'b0;
    end else if (tick_s) begin
      cnt_r <= '0;
      sck_r <= ~sck_r;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign sck      = sck_r;
  assign sck_rise = tick_s & ~sck_r;
  assign sck_fall = tick_s & sck_r;

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master (CPOL=0, CPHA=0) with per-transfer bit order and SCK rate.
// Define SPI_MASTER_BUSY_EN to add the busy status output.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic          mlb,
  input  logic [DW-1:0] tdat,
  input  logic [1:0]    cdiv,
  input  logic          din,
  output logic          ss,
  output logic          sck,
  output logic          dout,
  output logic          done,
  output logic [DW-1:0] rdata
`ifdef SPI_MASTER_BUSY_EN
  ,
  output logic          busy
`endif
);

  localparam int              BCW     = $clog2(DW);
  localparam logic [BCW-1:0]  BC_LAST = BCW'(DW - 1);
  localparam logic [BCW-1:0]  BC_ONE  = BCW'(1'b1);

  state_t          state_r, next_state_s;
  logic [DW-1:0]   tx_r, rx_r, rdata_r;
  logic [BCW-1:0]  bit_cnt_r;
  logic            mlb_r;
  logic [1:0]      cdiv_r;
  logic            ss_r, dout_r, done_r;
  logic            sck_s, sck_rise_s, sck_fall_s;
  logic [HCW-1:0]  half_m1_s;

  assign half_m1_s = half_m1(cdiv_r);

  spi_clk_div u_clk_div (
    .clk      (clk),
    .rstb     (rstb),
    .en       (state_r == SEND),
    .half_m1  (half_m1_s),
    .sck      (sck_s),
    .sck_rise (sck_rise_s),
    .sck_fall (sck_fall_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = SEND;
        else       next_state_s = IDLE;
      end
      SEND: begin
        if (sck_fall_s && (bit_cnt_r == BC_LAST)) next_state_s = FINISH;
        else                                      next_state_s = SEND;
      end
      FINISH:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Shift registers, bit counter and registered outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_r      <= '0;
      rx_r      <= '0;
      rdata_r   <= '0;
      bit_cnt_r <= '0;
      mlb_r     <= 1'b0;
      cdiv_r    <= 2'b00;
      ss_r      <= 1'b1;
      dout_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            // First bit goes straight to dout; tx_r holds the remaining bits
            tx_r      <= mlb ? {tdat[DW-2:0], 1'b0} : {1'b0, tdat[DW-1:1]};
            dout_r    <= mlb ? tdat[DW-1] : tdat[0];
            rx_r      <= '0;
            mlb_r     <= mlb;
            cdiv_r    <= cdiv;
            ss_r      <= 1'b0;
            bit_cnt_r <= '0;
          end
        end
        SEND: begin
          if (sck_rise_s) begin
            rx_r <= mlb_r ? {rx_r[DW-2:0], din} : {din, rx_r[DW-1:1]};
          end
          if (sck_fall_s) begin
            bit_cnt_r <= bit_cnt_r + BC_ONE;
            // After the last falling edge dout keeps the final bit
            if (bit_cnt_r != BC_LAST) begin
              dout_r <= mlb_r ? tx_r[DW-1] : tx_r[0];
              tx_r   <= mlb_r ? {tx_r[DW-2:0], 1'b0} : {1'b0, tx_r[DW-1:1]};
            end
          end
        end
        FINISH: begin
          ss_r    <= 1'b1;
          rdata_r <= rx_r;
          done_r  <= 1'b1;
        end
        default: begin
          ss_r <= 1'b1;
        end
      endcase
    end
  end

  assign ss    = ss_r;
  assign sck   = sck_s;
  assign dout  = dout_r;
  assign done  = done_r;
  assign rdata = rdata_r;
`ifdef SPI_MASTER_BUSY_EN
  assign busy  = (state_r != IDLE);
`endif

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed cases plus random transfers
// compared against a bit-level reference computed from the transfer rules.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rstb, start, mlb, din, ss, sck, dout, done;
  logic [7:0] tdat, rdata;
  logic [1:0] cdiv;
  logic       loop_en, din_drv;
`ifdef SPI_MASTER_BUSY_EN
  logic       busy;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign din = loop_en ? dout : din_drv;

  spi_master dut (
    .clk   (clk),
    .rstb  (rstb),
    .start (start),
    .mlb   (mlb),
    .tdat  (tdat),
    .cdiv  (cdiv),
    .din   (din),
    .ss    (ss),
    .sck   (sck),
    .dout  (dout),
    .done  (done),
    .rdata (rdata)
`ifdef SPI_MASTER_BUSY_EN
    ,
    .busy  (busy)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer; expectations come from tdat/mlb/cdiv and the din pattern.
  task automatic run_xfer(input string name, input logic [7:0] td, input logic m,
                          input logic [1:0] cd, input logic lp, input logic [7:0] pat,
                          input bit disturb);
    int h, rises, done_cnt, done_k, first_rise, second_rise, budget;
    logic prev_sck, exp_bit;
    bit ss_ok;
    logic [7:0] exp_rd;
    h = 2 << cd;
    budget = 16 * h + 6;
    exp_rd = lp ? td : pat;
    rises = 0; done_cnt = 0; done_k = -1; first_rise = -1; second_rise = -1;
    prev_sck = 1'b0; ss_ok = 1'b1;
    @(negedge clk);
    tdat = td; mlb = m; cdiv = cd; loop_en = lp; start = 1'b1;
    din_drv = m ? pat[7] : pat[0];
    @(posedge clk);
    for (int k = 0; k <= budget; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check({name, " ss_low"}, ss, 1'b0);
`ifdef SPI_MASTER_BUSY_EN
        check({name, " busy"}, busy, 1'b1);
`endif
      end
      if (k == 1) start = 1'b0;
      if (disturb && k == 20) begin
        start = 1'b1; tdat = ~td; cdiv = cd ^ 2'b11; mlb = ~m;
      end
      if (disturb && k == 40) start = 1'b0;
      if (ss && sck) ss_ok = 1'b0;
      if (sck && !prev_sck) begin
        if (rises < 8) begin
          exp_bit = m ? td[7 - rises] : td[rises];
          check($sformatf("%s dout_bit%0d", name, rises), dout, exp_bit);
        end
        if (rises == 0) first_rise = k;
        if (rises == 1) second_rise = k;
        rises++;
        if (rises < 8) din_drv = m ? pat[7 - rises] : pat[rises];
      end
      if (done) begin
        if (done_cnt == 0) done_k = k;
        done_cnt++;
      end
      prev_sck = sck;
    end
    check({name, " sck_pulses"}, rises, 8);
    check({name, " sck_period"}, second_rise - first_rise, 2 * h);
    check({name, " done_latency"}, done_k, 16 * h + 1);
    check({name, " done_count"}, done_cnt, 1);
    check({name, " rdata"}, rdata, exp_rd);
    check({name, " ss_idle"}, ss, 1'b1);
    check({name, " sck_idle"}, sck, 1'b0);
    check({name, " dout_hold"}, dout, m ? td[0] : td[7]);
    check({name, " sck_quiet_ss_high"}, ss_ok, 1'b1);
  endtask

  initial begin
    logic [7:0] r_td, r_pat;
    logic       r_m, r_lp;
    logic [1:0] r_cd;
    int         guard, rises;
    logic       prev_sck;

    rstb = 1'b0; start = 1'b0; mlb = 1'b0; tdat = 8'h00; cdiv = 2'b00;
    loop_en = 1'b0; din_drv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle", {ss, sck, dout, done, rdata}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    end

    run_xfer("loop_lsb_7C", 8'h7C, 1'b0, 2'b00, 1'b1, 8'h00, 1'b0);
    run_xfer("loop_msb_1C", 8'h1C, 1'b1, 2'b01, 1'b1, 8'h00, 1'b0);
    run_xfer("din1_A5",     8'hA5, 1'b1, 2'b11, 1'b0, 8'hFF, 1'b0);
    run_xfer("din0_A5",     8'hA5, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0);
    run_xfer("disturb",     8'h3B, 1'b1, 2'b01, 1'b1, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    check("no_restart_ss", ss, 1'b1);
    check("no_restart_done", done, 1'b0);

    for (int t = 0; t < 6; t++) begin
      r_td  = 8'($urandom);
      r_pat = 8'($urandom);
      r_m   = 1'($urandom);
      r_lp  = 1'($urandom);
      r_cd  = 2'($urandom_range(0, 2));
      run_xfer($sformatf("rand%0d", t), r_td, r_m, r_cd, r_lp, r_pat, 1'b0);
    end

    // Abort a transfer at the 4th sck pulse
    @(negedge clk);
    tdat = 8'h96; mlb = 1'b1; cdiv = 2'b00; loop_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; prev_sck = 1'b0; guard = 0;
    while (rises < 4 && guard < 200) begin
      @(negedge clk);
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
      guard++;
    end
    check("abort_reached_pulse4", rises, 4);
    rstb = 1'b0;
    #1;
    check("abort_outputs", {ss, sck, done, rdata}, {1'b1, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rstb = 1'b1;
    run_xfer("after_abort", 8'hC3, 1'b0, 2'b00, 1'b1, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
